ps2_receiver: RTL and testbench

Receives PS/2 keyboard frames from the debounced `ps2Clk`/`ps2Data` lines and delivers each scancode byte to the SoC keyboard logic over a valid/ready interface. It sits directly downstream of the PS/2 debouncer and upstream of the scancode decoder (shift/ctrl/alt/E0/F0 tracking). Parity, start/stop and inter-bit timeout are checked here. Bad frames are dropped and reported as one-cycle error pulses.

---
 rtl/ps2_receiver_pkg.sv | 21 ++
 rtl/ps2_receiver_if.sv | 37 +++
 rtl/ps2_receiver.sv | 168 ++++++++++++++++
 tb/tb_ps2_receiver.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_receiver_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_receiver_pkg;

  // Frame-level receiver states.
  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_t;

  // Data bits per PS/2 frame.
  localparam int unsigned Ps2DataBits = 8;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [Ps2DataBits-1:0] i_byte,
                                         input logic                   i_parity);
    return ^{i_byte, i_parity};
  endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// PS/2 line inputs plus the byte valid/ready channel and error pulses.
// The master side is the receiver (it sources bytes); the slave side is the
// environment that drives the PS/2 lines and consumes bytes.
interface ps2_receiver_if;

  logic                                    ps2_clk;
  logic                                    ps2_data;
  logic [ps2_receiver_pkg::Ps2DataBits-1:0] data;
  logic                                    valid;
  logic                                    ready;
  logic                                    parity_error;
  logic                                    frame_error;
  logic                                    overrun;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    input  ready,
    output data,
    output valid,
    output parity_error,
    output frame_error,
    output overrun
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    output ready,
    input  data,
    input  valid,
    input  parity_error,
    input  frame_error,
    input  overrun
  );

endinterface

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver: synchronises the debounced PS/2 lines, shifts in
// start/data/parity/stop on falling PS/2 clock edges, checks the frame and hands
// good bytes to a one-entry holding register with a valid/ready interface.
module ps2_receiver
  import ps2_receiver_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 4096
) (
  input logic            i_clk,
  input logic            i_reset,
  ps2_receiver_if.master io_bus
);

  localparam int unsigned CntW    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned BitCntW = $clog2(Ps2DataBits);

  localparam logic [CntW-1:0]    TimeoutMax = CntW'(TimeoutCycles - 1);
  localparam logic [BitCntW-1:0] LastBit    = BitCntW'(Ps2DataBits - 1);

  // Synchronisers and edge detect
  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_data_meta;
  logic r_data_sync;
  logic w_fall;

  // Frame state
  ps2_state_t             r_state;
  logic [Ps2DataBits-1:0] r_shift;
  logic                   r_parity;
  logic [BitCntW-1:0]     r_bit_cnt;
  logic [CntW-1:0]        r_tmo_cnt;

  // Frame verdicts for the current cycle
  logic w_timeout;
  logic w_stop_fall;
  logic w_frame_bad;
  logic w_parity_bad;
  logic w_good;

  // Holding register and pulse outputs
  logic [Ps2DataBits-1:0] r_data;
  logic                   r_valid;
  logic                   r_parity_error;
  logic                   r_frame_error;
  logic                   r_overrun;

  // Two-flop synchronisers (idle-high lines, so reset to 1) and previous clock sample.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= io_bus.ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= io_bus.ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  assign w_fall = ~r_clk_sync & r_clk_prev;

  // Classify this cycle: timeout, or the stop-bit edge ending a bad or good frame.
  always_comb begin
    w_timeout    = 1'b0;
    w_stop_fall  = 1'b0;
    w_frame_bad  = 1'b0;
    w_parity_bad = 1'b0;
    w_good       = 1'b0;
    // A falling edge in the expiry cycle wins over the timeout.
    w_timeout    = (r_state != StIdle) && !w_fall && (r_tmo_cnt == TimeoutMax);
    w_stop_fall  = (r_state == StStop) && w_fall;
    // Stop-bit error takes priority over parity error.
    w_frame_bad  = w_stop_fall && !r_data_sync;
    w_parity_bad = w_stop_fall && r_data_sync && !odd_parity_ok(r_shift, r_parity);
    w_good       = w_stop_fall && r_data_sync && odd_parity_ok(r_shift, r_parity);
  end

  // Frame FSM: shifts bits on falling PS/2 edges and aborts on inter-bit timeout.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      if (w_fall || (r_state == StIdle)) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (w_timeout) begin
        r_state   <= StIdle;
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_fall) begin
        unique case (r_state)
          StIdle: begin
            // A high bit while idle is line noise, not a start bit.
            if (!r_data_sync) begin
              r_state   <= StData;
              r_shift   <= '0;
              r_bit_cnt <= '0;
            end
          end
          StData: begin
            // LSB arrives first, so shift right and insert at the top.
            r_shift   <= {r_data_sync, r_shift[Ps2DataBits-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LastBit) begin
              r_state <= StParity;
            end
          end
          StParity: begin
            r_parity <= r_data_sync;
            r_state  <= StStop;
          end
          StStop: begin
            r_state <= StIdle;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  // One-entry holding register and one-cycle error/overrun pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data         <= '0;
      r_valid        <= 1'b0;
      r_parity_error <= 1'b0;
      r_frame_error  <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_parity_error <= w_parity_bad;
      r_frame_error  <= w_frame_bad | w_timeout;
      r_overrun      <= 1'b0;
      if (w_good) begin
        // Accept when empty or when the held byte leaves this same cycle.
        if (!r_valid || io_bus.ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && io_bus.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_bus.data         = r_data;
  assign io_bus.valid        = r_valid;
  assign io_bus.parity_error = r_parity_error;
  assign io_bus.frame_error  = r_frame_error;
  assign io_bus.overrun      = r_overrun;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed scenarios plus a randomized
// frame stream checked against a frame-level reference model.
module tb_ps2_receiver;

  localparam int unsigned TimeoutCycles = 64;
  // PS/2 bit period of 40 clk: 10 high, 20 low, 10 high; falls stay inside the timeout.
  localparam int unsigned PreLow  = 10;
  localparam int unsigned LowTime = 20;
  localparam int unsigned PostLow = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ps2_receiver_if dif ();

  ps2_receiver #(
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (dif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Observed activity
  int         cyc          = 0;
  int         cnt_par      = 0;
  int         cnt_frm      = 0;
  int         cnt_ovr      = 0;
  int         cnt_wide     = 0;
  int         cnt_both     = 0;
  int         last_frm_cyc = 0;
  logic       prev_par     = 1'b0;
  logic       prev_frm     = 1'b0;
  logic       prev_ovr     = 1'b0;
  logic [7:0] got_q[$];

  // Reference model state
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_par   = 0;
  int         m_frm   = 0;
  int         m_ovr   = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (dif.valid && dif.ready) got_q.push_back(dif.data);
      if (dif.parity_error) cnt_par <= cnt_par + 1;
      if (dif.frame_error) begin
        cnt_frm      <= cnt_frm + 1;
        last_frm_cyc <= cyc;
      end
      if (dif.overrun) cnt_ovr <= cnt_ovr + 1;
      if ((dif.parity_error && prev_par) || (dif.frame_error && prev_frm) ||
          (dif.overrun && prev_ovr)) cnt_wide <= cnt_wide + 1;
      if (dif.parity_error && dif.frame_error) cnt_both <= cnt_both + 1;
    end
    prev_par <= dif.parity_error;
    prev_frm <= dif.frame_error;
    prev_ovr <= dif.overrun;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Parity bit that gives data+parity an odd number of ones.
  function automatic logic good_parity(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // Frame-level model: classify the frame, then apply holding-register rules.
  task automatic model_frame(input logic [7:0] b, input logic p, input logic s);
    if (!s) begin
      m_frm++;
    end else if (($countones({b, p}) % 2) == 0) begin
      m_par++;
    end else if (dif.ready) begin
      if (m_valid) exp_q.push_back(m_data);
      exp_q.push_back(b);
      m_data  = b;
      m_valid = 1'b0;
    end else if (m_valid) begin
      m_ovr++;
    end else begin
      m_valid = 1'b1;
      m_data  = b;
    end
  endtask

  task automatic model_consume();
    if (m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    dif.ps2_data = b;
    tick(PreLow);
    dif.ps2_clk = 1'b0;
    tick(LowTime);
    dif.ps2_clk = 1'b1;
    tick(PostLow);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    model_frame(b, p, s);
  endtask

  task automatic test_reset();
    dif.ps2_clk  = 1'b1;
    dif.ps2_data = 1'b1;
    dif.ready    = 1'b0;
    reset        = 1'b1;
    tick(5);
    n_cmp++; if (dif.data !== 8'h00) begin
      n_err++; $display("FAIL reset_data: got %h want 00", dif.data); end
    n_cmp++; if (dif.valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", dif.valid); end
    n_cmp++; if (dif.parity_error !== 1'b0) begin
      n_err++; $display("FAIL reset_perr: got %b want 0", dif.parity_error); end
    n_cmp++; if (dif.frame_error !== 1'b0) begin
      n_err++; $display("FAIL reset_ferr: got %b want 0", dif.frame_error); end
    n_cmp++; if (dif.overrun !== 1'b0) begin
      n_err++; $display("FAIL reset_ovr: got %b want 0", dif.overrun); end
    reset = 1'b0;
    tick(5);
    n_cmp++; if (dif.valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_valid: got %b want 0", dif.valid); end
  endtask

  task automatic test_good_byte();
    logic [9:0] bits;
    bits = {1'b0, 8'h1C, 1'b0};
    dif.ready = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    // Stop bit by hand to watch the latency edge by edge.
    dif.ps2_data = 1'b1;
    tick(PreLow);
    dif.ps2_clk = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      n_cmp++; if (dif.valid !== (e == 3)) begin
        n_err++; $display("FAIL good_latency edge %0d: valid got %b want %b", e, dif.valid, e == 3);
      end
    end
    tick(LowTime - 3);
    dif.ps2_clk = 1'b1;
    tick(PostLow);
    model_frame(8'h1C, 1'b0, 1'b1);
    n_cmp++; if (dif.data !== 8'h1C) begin
      n_err++; $display("FAIL good_data: got %h want 1c", dif.data); end
    dif.ready = 1'b1;
    model_consume();
    tick(1);
    dif.ready = 1'b0;
    n_cmp++; if (dif.valid !== 1'b0) begin
      n_err++; $display("FAIL good_valid_drop: got %b want 0", dif.valid); end
    tick(2);
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h1C) begin
      n_err++; $display("FAIL good_handshake: got %0d bytes first %h want 1 byte 1c",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    dif.ready = 1'b1;
    tick(2);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    tick(5);
    dif.ready = 1'b0;
    n_cmp++; if (got_q.size() != 2) begin
      n_err++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    else begin
      n_cmp++; if (got_q[0] !== 8'hF0) begin
        n_err++; $display("FAIL b2b_first: got %h want f0", got_q[0]); end
      n_cmp++; if (got_q[1] !== 8'h1C) begin
        n_err++; $display("FAIL b2b_second: got %h want 1c", got_q[1]); end
    end
    n_cmp++; if (cnt_par + cnt_frm + cnt_ovr != 0) begin
      n_err++; $display("FAIL b2b_errors: got %0d pulses want 0", cnt_par + cnt_frm + cnt_ovr);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_parity_error();
    dif.ready = 1'b0;
    send_frame(8'h1C, 1'b1, 1'b1);
    tick(5);
    n_cmp++; if (cnt_par != 1) begin
      n_err++; $display("FAIL parity_pulse: got %0d want 1", cnt_par); end
    n_cmp++; if (dif.valid !== 1'b0) begin
      n_err++; $display("FAIL parity_valid: got %b want 0", dif.valid); end
    n_cmp++; if (cnt_frm != m_frm) begin
      n_err++; $display("FAIL parity_no_ferr: got %0d want %0d", cnt_frm, m_frm); end
  endtask

  task automatic test_bad_stop();
    dif.ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0);
    dif.ps2_data = 1'b1;
    tick(5);
    n_cmp++; if (cnt_frm != 1) begin
      n_err++; $display("FAIL stop_pulse: got %0d want 1", cnt_frm); end
    n_cmp++; if (dif.valid !== 1'b0) begin
      n_err++; $display("FAIL stop_valid: got %b want 0", dif.valid); end
    n_cmp++; if (cnt_par != m_par) begin
      n_err++; $display("FAIL stop_no_perr: got %0d want %0d", cnt_par, m_par); end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    int         t_low;
    b         = 8'h1C;
    dif.ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    dif.ps2_data = b[4];
    tick(PreLow);
    t_low       = cyc;
    dif.ps2_clk = 1'b0;
    tick(LowTime);
    dif.ps2_clk = 1'b1;
    m_frm++;
    tick(100);
    n_cmp++; if (cnt_frm != m_frm) begin
      n_err++; $display("FAIL timeout_pulse: got %0d want %0d", cnt_frm, m_frm); end
    // 2-flop sync + edge register, 63-cycle count, one registered output stage.
    n_cmp++; if (last_frm_cyc - t_low < 66 || last_frm_cyc - t_low > 68) begin
      n_err++; $display("FAIL timeout_delay: got %0d cycles want 66..68", last_frm_cyc - t_low);
    end
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(5);
    dif.ready = 1'b0;
    n_cmp++; if (dif.data !== 8'h5A) begin
      n_err++; $display("FAIL timeout_recover_data: got %h want 5a", dif.data); end
    n_cmp++; if (got_q.size() != 1) begin
      n_err++; $display("FAIL timeout_recover_count: got %0d want 1", got_q.size()); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overrun();
    dif.ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    tick(5);
    n_cmp++; if (cnt_ovr != 1) begin
      n_err++; $display("FAIL overrun_pulse: got %0d want 1", cnt_ovr); end
    n_cmp++; if (dif.data !== 8'h1C) begin
      n_err++; $display("FAIL overrun_data: got %h want 1c", dif.data); end
    n_cmp++; if (dif.valid !== 1'b1) begin
      n_err++; $display("FAIL overrun_valid: got %b want 1", dif.valid); end
    dif.ready = 1'b1;
    model_consume();
    tick(1);
    dif.ready = 1'b0;
    tick(2);
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h1C) begin
      n_err++; $display("FAIL overrun_drain: got %0d bytes want 1 byte 1c", got_q.size()); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b         = 8'h1C;
    dif.ready = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    reset = 1'b1;
    tick(3);
    m_valid = 1'b0;
    m_data  = 8'h00;
    n_cmp++; if (dif.data !== 8'h00) begin
      n_err++; $display("FAIL midreset_data: got %h want 00", dif.data); end
    n_cmp++; if (dif.valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_valid: got %b want 0", dif.valid); end
    n_cmp++; if ({dif.parity_error, dif.frame_error, dif.overrun} !== 3'b000) begin
      n_err++; $display("FAIL midreset_pulses: got %b want 000",
                        {dif.parity_error, dif.frame_error, dif.overrun});
    end
    dif.ps2_data = 1'b1;
    reset        = 1'b0;
    tick(20);
    send_frame(8'h1C, 1'b0, 1'b1);
    tick(5);
    n_cmp++; if (dif.data !== 8'h1C || dif.valid !== 1'b1) begin
      n_err++; $display("FAIL midreset_recover: got %h/%b want 1c/1", dif.data, dif.valid); end
    n_cmp++; if (cnt_frm != m_frm || cnt_par != m_par) begin
      n_err++; $display("FAIL midreset_silent: got ferr %0d perr %0d want %0d %0d",
                        cnt_frm, cnt_par, m_frm, m_par);
    end
    dif.ready = 1'b1;
    model_consume();
    tick(2);
    dif.ready = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       p;
    logic       s;
    int         kind;
    for (int n = 0; n < 16; n++) begin
      b         = 8'($urandom);
      kind      = $urandom_range(0, 5);
      dif.ready = 1'($urandom_range(0, 1));
      if (dif.ready) model_consume();
      tick(3);
      p = good_parity(b);
      s = 1'b1;
      if (kind == 0) p = ~p;
      if (kind == 1) s = 1'b0;
      send_frame(b, p, s);
      dif.ps2_data = 1'b1;
      tick(5);
      n_cmp++; if (dif.valid !== m_valid || dif.data !== m_data) begin
        n_err++; $display("FAIL rand%0d_hold: got %b/%h want %b/%h",
                          n, dif.valid, dif.data, m_valid, m_data);
      end
      n_cmp++; if (cnt_par != m_par || cnt_frm != m_frm || cnt_ovr != m_ovr) begin
        n_err++; $display("FAIL rand%0d_pulses: got p%0d f%0d o%0d want p%0d f%0d o%0d",
                          n, cnt_par, cnt_frm, cnt_ovr, m_par, m_frm, m_ovr);
      end
    end
    dif.ready = 1'b1;
    model_consume();
    tick(3);
    dif.ready = 1'b0;
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (cnt_wide != 0) begin
      n_err++; $display("FAIL pulse_width: got %0d wide pulses want 0", cnt_wide); end
    n_cmp++; if (cnt_both != 0) begin
      n_err++; $display("FAIL both_errors: got %0d overlaps want 0", cnt_both); end
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_back_to_back();
    test_parity_error();
    test_bad_stop();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
